// File: rtl/nb_rd_seq_pkg.sv
// rtl/nb_rd_seq_pkg.sv - shared widths and state encoding for the neuron buffer read sequencer
package nb_rd_seq_pkg;
    localparam int N         = 16;
    localparam int TN        = 16;
    localparam int NXTN      = N * TN;
    localparam int ADDR      = 6;
    localparam int NUM_WORDS = 64;
    localparam int LEN_W     = ADDR + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
endpackage

// File: rtl/nb_rd_q.sv
// rtl/nb_rd_q.sv - 2-entry valid/ready FIFO with a registered head word
module nb_rd_q
    import nb_rd_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [NXTN-1:0] push_data,
    input  logic            ready,
    output logic            valid,
    output logic [NXTN-1:0] data,
    output logic            pop,
    output logic [1:0]      occ
);
    logic [NXTN-1:0] tail;
    logic [1:0]      wr_slot;
    logic            do_push;

    assign valid   = (occ != 2'd0);
    assign pop     = valid && ready;
    assign do_push = push && ((occ != 2'd2) || pop);
    // Slot the incoming word lands in once this cycle's pop has shifted the tail forward.
    assign wr_slot = occ - {1'b0, pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            occ  <= 2'd0;
            data <= '0;
            tail <= '0;
        end else begin
            if (pop) begin
                data <= tail;
            end
            if (do_push) begin
                if (wr_slot == 2'd0) begin
                    data <= push_data;
                end else begin
                    tail <= push_data;
                end
            end
            occ <= occ + {1'b0, do_push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/nb_rd_seq.sv
// rtl/nb_rd_seq.sv - burst read sequencer streaming neuron buffer words downstream
module nb_rd_seq
    import nb_rd_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [ADDR-1:0]  i_base,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic [ADDR-1:0]  o_addr,
    output logic             o_wen,
    input  logic [NXTN-1:0]  i_mem_data,
    output logic             o_valid,
    output logic [NXTN-1:0]  o_data,
    input  logic             i_ready
);
    logic [1:0]       state;
    logic [LEN_W-1:0] rem;
    logic             inflight;
    logic             issue;
    logic             pop;
    logic [1:0]       occ;
    logic [2:0]       credit_used;
    logic [2:0]       credit_cap;
    logic             drained;

    assign o_wen  = 1'b1;
    assign o_busy = (state != ST_IDLE);

    // o_addr doubles as the read pointer: the word it names is read by the buffer at the
    // end of this cycle, so a read is only issued when the queue can absorb it.
    assign credit_used = {1'b0, occ} + {2'b00, inflight};
    assign credit_cap  = 3'd2 + {2'b00, pop};
    assign issue       = (state == ST_RUN) && (rem != '0) && (credit_used < credit_cap);
    assign drained     = !inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop));

    nb_rd_q u_q (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (i_mem_data),
        .ready     (i_ready),
        .valid     (o_valid),
        .data      (o_data),
        .pop       (pop),
        .occ       (occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rem      <= '0;
            o_addr   <= '0;
            inflight <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_done   <= 1'b0;
            inflight <= issue;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_len == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            o_addr <= i_base;
                            rem    <= i_len;
                            state  <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        rem <= rem - LEN_W'(1);
                        // Keep the last address on the bus once the final read is out.
                        if (rem != LEN_W'(1)) begin
                            o_addr <= o_addr + ADDR'(1);
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        o_done <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nb_rd_seq.sv
// tb/tb_nb_rd_seq.sv - self-checking bench for nb_rd_seq against a burst-level reference model
module tb_nb_rd_seq;
    import nb_rd_seq_pkg::*;

    logic             clk;
    logic             rst;
    logic             i_start;
    logic [ADDR-1:0]  i_base;
    logic [LEN_W-1:0] i_len;
    logic             o_busy;
    logic             o_done;
    logic [ADDR-1:0]  o_addr;
    logic             o_wen;
    logic [NXTN-1:0]  i_mem_data;
    logic             o_valid;
    logic [NXTN-1:0]  o_data;
    logic             i_ready;

    logic [NXTN-1:0]  mem [NUM_WORDS];
    int tests;
    int fails;

    nb_rd_seq dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_base     (i_base),
        .i_len      (i_len),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_addr     (o_addr),
        .o_wen      (o_wen),
        .i_mem_data (i_mem_data),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .i_ready    (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous buffer: Q shows the addressed word the cycle after the address is sampled.
    always @(posedge clk) i_mem_data <= mem[o_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_d(input string tag, input logic [NXTN-1:0] obs, input logic [NXTN-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_pattern();
        for (int k = 0; k < NUM_WORDS; k++) begin
            logic [15:0] v;
            v = 16'(k);
            mem[k] = {16{v}};
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < NUM_WORDS; k++)
            for (int j = 0; j < NXTN / 32; j++)
                mem[k][32*j +: 32] = $urandom;
    endtask

    // Caller is positioned at a negedge; that cycle becomes cycle 0 of the burst.
    // Returns at the negedge of the o_done cycle without driving that cycle, so a
    // following call starts its burst in the o_done cycle.
    task automatic run_burst(input int base, input int len, input bit rnd_ready, input int stray_cyc);
        logic [NXTN-1:0] exp_q[$];
        logic [NXTN-1:0] held;
        logic [ADDR-1:0] addr0;
        bit stalled;
        int beats, last_beat, done_cyc, budget;
        stalled = 1'b0;
        beats = 0;
        last_beat = 0;
        done_cyc = -1;
        held = '0;
        budget = 4 * len + 40;
        for (int k = 0; k < len; k++) exp_q.push_back(mem[(base + k) % NUM_WORDS]);
        addr0 = o_addr;
        check("idle_before_start", 32'(o_busy), 32'd0);
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc > 0 && o_done) begin
                done_cyc = cyc;
                break;
            end
            i_start = (cyc == 0) || (cyc == stray_cyc);
            i_base  = (cyc == 0) ? ADDR'(base) : ~ADDR'(base);
            i_len   = (cyc == 0) ? LEN_W'(len) : LEN_W'(5);
            i_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!rnd_ready && cyc >= 1 && cyc <= len)
                check("addr_seq", 32'(o_addr), 32'((base + cyc - 1) % NUM_WORDS));
            if (stalled) begin
                check("stall_valid", 32'(o_valid), 32'd1);
                check_d("stall_data", o_data, held);
            end
            if (cyc > 0 && o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("beat_overrun", 32'(beats + 1), 32'(len));
                end else begin
                    check_d("beat_data", o_data, exp_q.pop_front());
                    if (!rnd_ready) check("beat_cycle", 32'(cyc), 32'(beats + 3));
                end
                beats++;
                last_beat = cyc;
            end
            stalled = o_valid && !i_ready;
            held = o_data;
        end
        i_start = 1'b0;
        check("beat_total", 32'(beats), 32'(len));
        if (len == 0) check("done_cycle", 32'(done_cyc), 32'd1);
        else if (!rnd_ready) check("done_cycle", 32'(done_cyc), 32'(len + 3));
        else check("done_cycle", 32'(done_cyc), 32'(last_beat + 1));
        if (done_cyc > 0) begin
            check("done_busy", 32'(o_busy), 32'd0);
            check("done_valid", 32'(o_valid), 32'd0);
            check("done_addr", 32'(o_addr),
                  (len == 0) ? 32'(addr0) : 32'((base + len - 1) % NUM_WORDS));
        end
    endtask

    task automatic idle(input int n);
        i_start = 1'b0;
        i_ready = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        i_start = 1'b0;
        i_base = '0;
        i_len = '0;
        i_ready = 1'b1;
        fill_pattern();
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_addr", 32'(o_addr), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check_d("rst_data", o_data, '0);
        check("wen_tied", 32'(o_wen), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        run_burst(5, 4, 1'b0, -1);
        idle(3);
        run_burst(62, 4, 1'b0, -1);
        idle(2);
        run_burst(30, 0, 1'b0, -1);
        idle(2);
        run_burst(0, 64, 1'b0, -1);
        idle(2);
        run_burst(10, 4, 1'b0, 3);
        idle(1);
        run_burst(50, 3, 1'b0, -1);
        run_burst(12, 5, 1'b0, -1);
        idle(2);

        fill_random();
        for (int t = 0; t < 4; t++) begin
            run_burst(int'($urandom_range(0, 63)), 8, 1'b1, -1);
            idle(1);
        end

        // Reset in cycle 5 of a 10-word burst.
        i_start = 1'b1;
        i_base = ADDR'(20);
        i_len = LEN_W'(10);
        i_ready = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 32'(o_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", 32'(o_valid), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_done", 32'(o_done), 32'd0);
        check("abort_addr", 32'(o_addr), 32'd0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("abort_no_done", 32'(o_done), 32'd0);
            check("abort_no_valid", 32'(o_valid), 32'd0);
        end
        run_burst(40, 2, 1'b0, -1);
        idle(1);

        for (int t = 0; t < 6; t++) begin
            fill_random();
            run_burst(int'($urandom_range(0, 63)), int'($urandom_range(1, 64)),
                      1'($urandom_range(0, 1)), int'($urandom_range(2, 6)));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nb_rd_seq.md
Name: nb_rd_seq

Overview:
- Read-side sequencer for the 64-word x 256-bit neuron buffer.
- Accepts a burst command (base address, length) and drives the buffer read address.
- Absorbs the buffer's 1-cycle read latency and streams words downstream on a valid/ready interface.
- Backpressure never loses or duplicates a word; a 2-entry output queue decouples SRAM reads from the consumer.

Parameters:
- N, 16, bits per neuron value
- Tn, 16, neurons per buffer word
- NxTn, N*Tn, buffer word width (256)
- ADDR, 6, buffer address width
- NUM_WORDS, 64, buffer depth; must equal 2**ADDR
- LEN_W, ADDR+1, burst length field width (0..NUM_WORDS)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- i_start  in  1  command strobe; sampled only in IDLE
- i_base  in  ADDR  first word address of burst
- i_len  in  LEN_W  number of words to read (0..64)
- o_busy  out  1  high while not IDLE
- o_done  out  1  one-cycle pulse when burst complete
- o_addr  out  ADDR  buffer address (registered)
- o_wen  out  1  buffer write enable, active-low; tied 1 (read only)
- i_mem_data  in  NxTn  buffer Q; valid the cycle after the address edge
- o_valid  out  1  output word valid
- o_data  out  NxTn  output word
- i_ready  in  1  consumer accepts when o_valid && i_ready

Behaviour:
- Reset values (rst high at an edge): o_busy=0, o_done=0, o_addr=0, o_valid=0, o_data=0, queue empty, inflight=0, state IDLE. o_wen=1 always.
- Reset mid-burst aborts the burst: in-flight and queued words are discarded and no o_done is produced.
- States:
  - IDLE: on i_start, latch base and len.
    - len==0: o_done pulses next cycle; stay IDLE.
    - Otherwise: cur=base, rem=len, go to RUN.
  - RUN: issue reads until rem==0, then go to DRAIN.
  - DRAIN: wait until inflight==0 and the queue is empty after the last pop, pulse o_done, go to IDLE.
- i_start is ignored outside IDLE. No command queueing.
- Issue condition in cycle t: rem>0 && (occ + inflight) < 2 + (o_valid && i_ready).
  - On issue: o_addr<=cur at the edge; cur<=cur+1 modulo NUM_WORDS (address 63 wraps to 0); rem<=rem-1; inflight<=1 for the next cycle.
  - Inflight is at most 1 by construction.
- Capture: in the cycle after an issue edge, i_mem_data is written into the queue at the next edge. The capture must never target a full queue; this is guaranteed by the issue condition.
- Queue: 2-entry FIFO with registered head. o_valid=(occ>0) and o_data=head.
  - Push and pop in the same cycle keep occ unchanged with order preserved.
  - o_data is held stable while o_valid && !i_ready.
- Latency: i_start in cycle 0 gives o_addr=base in cycle 1, data capture at the end of cycle 2, and o_valid high in cycle 3.
- Throughput: with i_ready held high, one word per cycle. A 64-word burst has its last beat in cycle 66 and o_done in cycle 67.
- o_done asserts the cycle after the last beat is accepted. o_busy falls in the same cycle as o_done and the block is back in IDLE. A new i_start may be issued in that o_done cycle.
- o_addr holds its last value in IDLE; the buffer's idle reads are harmless.

Decomposition:
- Shared package: word width NxTn, ADDR, NUM_WORDS, LEN_W constants, and the state encoding (IDLE/RUN/DRAIN).
- One natural sub-module: nb_rd_q, a 2-entry valid/ready FIFO of NxTn bits with push, pop, and occ outputs.
- The FSM, address counter, and credit logic stay in the top level.

Test Plan:
- Basic burst: base=5, len=4, i_ready=1, memory word k = {16{k[15:0]}} -> o_addr 5,6,7,8 in cycles 1-4; beats of words 5,6,7,8 in cycles 3-6; o_done in cycle 7.
- Wrap-around: base=62, len=4 -> addresses 62,63,0,1; data order matches; o_done once.
- Backpressure: len=8, i_ready toggles 1,0,0,1,... randomly -> exactly 8 beats in order; no drops or duplicates; o_data stable while stalled; occ never exceeds 2.
- Edge lengths:
  - len=0 -> o_done in cycle 1, no o_valid, no address change.
  - len=64 with base=0 -> all 64 words; last beat in cycle 66.
- i_start ignored while busy: a second start mid-burst has no effect. A start in the o_done cycle begins a new burst correctly.
- Reset mid-burst: rst at cycle 5 of a len=10 burst -> next cycle o_valid=0, o_busy=0, no o_done. A following len=2 burst behaves like a fresh burst.
